rx_ipv4: RTL
============

// Module: rx_ipv4
// PURPOSE
//  IPv4 receive layer; sits directly downstream of the Ethernet receive stage on the GMII RX clock.
//  Consumes the EtherType-0x0800 payload byte stream and parses/validates the IPv4 header:
//  version, IHL, header checksum, destination IP. For accepted UDP datagrams it forwards the
//  payload bytes, strips Ethernet padding, and pulses a completion interrupt.
// PARAMETERS
//  OCT        8        bits per byte
//  PROTO_UDP  8'h11    IPv4 protocol number forwarded downstream
//  IP_BCAST   32'hFFFFFFFF  broadcast destination, always accepted
// PORTS
//  RX_CLK           in   1      receive clock (sole clock)
//  rst              in   1      asynchronous, active-high reset
//  ip_addr          in   32     local IPv4 address; static while a datagram is in flight
//  rx_payload_ipv4  in   1      byte-valid from the Ethernet stage; high for contiguous bytes of one frame
//  rx_payload       in   OCT    payload byte; qualified by rx_payload_ipv4
//  rx_payload_udp   out  1      UDP payload byte valid
//  rx_udp_data      out  OCT    UDP payload byte (IP payload, starting with the UDP header)
//  rx_ip_src        out  32     source IP of the current/last datagram
//  rx_ip_len        out  16     IP payload length = total_length - 4*IHL
//  rx_ip_err        out  3      {bad_hdr, bad_csum, truncated}; valid with rv_irq_ipv4
//  rv_irq_ipv4      out  1      one-cycle pulse: datagram finished or aborted
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters and checksum accumulator cleared. Reset mid-frame
//   aborts silently (no irq); the next datagram starts on the next valid rising edge.
//  Datagram start = rising edge of rx_payload_ipv4 (0 in previous cycle). Valid must be low >=1 cycle between frames.
//  FSM: IDLE -> HDR -> OPT -> PAYLOAD -> DRAIN -> DONE -> IDLE.
//   IDLE: wait for start; the byte in the start cycle is header byte 0.
//   HDR: bytes 0..19. Byte0[7:4]!=4 or byte0[3:0]<5 -> bad_hdr. Bytes 2-3 total_length (big-endian);
//        total_length < 4*IHL -> bad_hdr. Byte 9 protocol; bytes 12-15 -> rx_ip_src; bytes 16-19 dst.
//        Byte 19 -> OPT if IHL>5, else PAYLOAD.
//   OPT: skip (IHL-5)*4 bytes; included in the checksum.
//   Accept decision on the last header byte, evaluated combinationally with that byte:
//        no bad_hdr, checksum OK, dst==ip_addr or IP_BCAST. Protocol != PROTO_UDP or dst mismatch
//        -> DRAIN with no error and no forwarding. bad_hdr/bad_csum -> DRAIN with the error flag set.
//   PAYLOAD: forward rx_ip_len bytes; rx_payload_udp/rx_udp_data are registered, 1-cycle latency from input.
//        After the last payload byte -> DRAIN. rx_ip_len==0 -> DRAIN directly.
//   DRAIN: discard remaining bytes (Ethernet padding, FCS) until valid falls -> DONE.
//   DONE: rv_irq_ipv4=1 for exactly one cycle with rx_ip_err; rx_ip_src/rx_ip_len held until next start.
//  Valid falling in HDR/OPT/PAYLOAD before the expected byte count sets truncated, ends forwarding,
//   and goes straight to DONE. The irq still pulses; payload already forwarded is not retracted.
//  Checksum: 16-bit one's-complement sum of all header words; even byte = high octet.
//   17-bit accumulator with end-around carry folded each word. Header valid iff final sum == 16'hFFFF.
//  Byte counter: 16 bits, saturating; never wraps within a 1518-byte frame.
//  IDLE sees a start in the same cycle DONE completes: impossible by the >=1 low-cycle rule.
//  Neither DONE nor IDLE drops such a start.
// STRUCTURE
//  Shared include vthernet_defs.vh: ETH_IPV4 16'h0800, PROTO_UDP/PROTO_ICMP, IP_BCAST,
//   rx_ipv4 state encodings, err bit indices.
//  Sub-module ipv4_csum: byte-wise one's-complement accumulator (clr, en, byte, odd/even phase -> sum_ok).
//   Reused by the later TX IPv4 header generator.
// TESTING
//  1 Valid UDP, IHL=5, dst=ip_addr, total_length=28, 28 bytes + 18 pad -> 8 payload bytes forwarded,
//    1-cycle latency; irq with err=000; rx_ip_len=8.
//  2 Same frame with checksum byte 10 flipped -> 0 bytes forwarded, irq with err=010.
//  3 IHL=6 (4 option bytes), dst=255.255.255.255 -> payload forwarded after byte 24; err=000.
//  4 Protocol 0x01 (ICMP) or dst mismatch -> no forwarding, irq err=000 after valid falls.
//  5 Valid drops after byte 12 -> irq err=001 the cycle after the drop; rst asserted mid-payload
//    -> outputs 0 at once, no irq.
//  6 Byte0=0x46 with total_length=20 (<24) -> bad_hdr err=100; back-to-back frames,
//    1-cycle gap -> both parsed.

Source files
------------

// File: rtl/rx_ipv4_pkg.sv
// Shared constants, FSM encoding and checksum helper for the IPv4 receive path.
package rx_ipv4_pkg;

  localparam int          OCT       = 8;
  localparam logic [7:0]  PROTO_UDP = 8'h11;
  localparam logic [31:0] IP_BCAST  = 32'hFFFF_FFFF;

  // Bit positions inside rx_ip_err = {bad_hdr, bad_csum, truncated}.
  localparam int ERR_HDR   = 2;
  localparam int ERR_CSUM  = 1;
  localparam int ERR_TRUNC = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_OPT,
    ST_PAYLOAD,
    ST_DRAIN,
    ST_DONE
  } rx_state_e;

  // One's-complement add with the end-around carry folded back in.
  function automatic logic [15:0] ocsum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/rx_ipv4_csum.sv
// Byte-serial IPv4 header checksum accumulator; even bytes are the high octet of a word.
// sum_ok_o reflects the sum including the odd byte presented in the current cycle.
module rx_ipv4_csum
  import rx_ipv4_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic           odd_i,
  input  logic [OCT-1:0] byte_i,
  output logic           sum_ok_o
);

  logic [15:0]    acc_q, acc_d, acc_base, word_sum;
  logic [OCT-1:0] hi_q, hi_d;

  always_comb begin
    acc_base = clr_i ? 16'd0 : acc_q;
    word_sum = ocsum_add(acc_base, {hi_q, byte_i});
    acc_d    = acc_q;
    hi_d     = hi_q;
    if (en_i) begin
      if (odd_i) begin
        acc_d = word_sum;
      end else begin
        hi_d  = byte_i;
        acc_d = acc_base;
      end
    end else if (clr_i) begin
      acc_d = 16'd0;
    end
  end

  assign sum_ok_o = odd_i && (word_sum == 16'hFFFF);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= 16'd0;
      hi_q  <= '0;
    end else begin
      acc_q <= acc_d;
      hi_q  <= hi_d;
    end
  end

endmodule

// File: rtl/rx_ipv4.sv
// IPv4 receive layer: parses/validates the header of an EtherType-0x0800 payload stream
// and forwards the payload of accepted UDP datagrams with one cycle of latency.
module rx_ipv4
  import rx_ipv4_pkg::*;
(
  input  logic           RX_CLK,
  input  logic           rst,
  input  logic [31:0]    ip_addr,
  input  logic           rx_payload_ipv4,
  input  logic [OCT-1:0] rx_payload,
  output logic           rx_payload_udp,
  output logic [OCT-1:0] rx_udp_data,
  output logic [31:0]    rx_ip_src,
  output logic [15:0]    rx_ip_len,
  output logic [2:0]     rx_ip_err,
  output logic           rv_irq_ipv4,
  output rx_state_e      dbg_state_o
);

  rx_state_e      state_q, state_d;
  logic           vld_prev_q;
  logic [15:0]    cnt_q, cnt_d;
  logic [3:0]     ihl_q, ihl_d;
  logic [15:0]    tl_q, tl_d;
  logic [7:0]     proto_q, proto_d;
  logic [31:0]    src_q, src_d;
  logic [31:0]    dst_q, dst_d;
  logic [15:0]    len_q, len_d;
  logic           bad_hdr_q, bad_hdr_d;
  logic [2:0]     err_q, err_d;
  logic           fwd_q, fwd_d;
  logic [OCT-1:0] data_q, data_d;

  logic        start, take_start, in_hdr, csum_ok, accept;
  logic [15:0] idx, ihl4, hdr_last, tl_cur;
  logic [31:0] dst_cur;

  // A start is accepted in DONE as well: a one-cycle gap lands the next byte 0 there.
  assign start      = rx_payload_ipv4 && !vld_prev_q;
  assign take_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign idx        = take_start ? 16'd0 : cnt_q;
  assign in_hdr     = take_start ||
                      (((state_q == ST_HDR) || (state_q == ST_OPT)) && rx_payload_ipv4);
  assign ihl4       = {10'd0, ihl_q, 2'b00};
  assign hdr_last   = ((ihl_q < 4'd5) ? 16'd20 : ihl4) - 16'd1;
  assign tl_cur     = {tl_q[15:8], rx_payload};
  assign dst_cur    = (idx == 16'd19) ? {dst_q[31:8], rx_payload} : dst_q;
  assign accept     = !bad_hdr_q && csum_ok && (proto_q == PROTO_UDP) &&
                      ((dst_cur == ip_addr) || (dst_cur == IP_BCAST));

  rx_ipv4_csum u_csum (
    .clk_i    (RX_CLK),
    .rst_i    (rst),
    .clr_i    (take_start),
    .en_i     (in_hdr),
    .odd_i    (idx[0]),
    .byte_i   (rx_payload),
    .sum_ok_o (csum_ok)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ihl_d     = ihl_q;
    tl_d      = tl_q;
    proto_d   = proto_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    bad_hdr_d = bad_hdr_q;
    err_d     = err_q;
    fwd_d     = 1'b0;
    data_d    = data_q;

    if (take_start) begin
      cnt_d = 16'd1;
      err_d = 3'b000;
    end else if (rx_payload_ipv4 && (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                 (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (in_hdr) begin
      case (idx)
        16'd0: begin
          ihl_d     = rx_payload[3:0];
          bad_hdr_d = (rx_payload[7:4] != 4'd4) || (rx_payload[3:0] < 4'd5);
        end
        16'd2: tl_d[15:8] = rx_payload;
        16'd3: begin
          tl_d[7:0] = rx_payload;
          if (tl_cur < ihl4) begin
            bad_hdr_d = 1'b1;
            len_d     = 16'd0;
          end else begin
            len_d = tl_cur - ihl4;
          end
        end
        16'd9:  proto_d         = rx_payload;
        16'd12: src_d[31:24]    = rx_payload;
        16'd13: src_d[23:16]    = rx_payload;
        16'd14: src_d[15:8]     = rx_payload;
        16'd15: src_d[7:0]      = rx_payload;
        16'd16: dst_d[31:24]    = rx_payload;
        16'd17: dst_d[23:16]    = rx_payload;
        16'd18: dst_d[15:8]     = rx_payload;
        16'd19: dst_d[7:0]      = rx_payload;
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE, ST_DONE: state_d = start ? ST_HDR : ST_IDLE;
      ST_HDR, ST_OPT: begin
        if (!rx_payload_ipv4) begin
          err_d[ERR_TRUNC] = 1'b1;
          state_d          = ST_DONE;
        end else if (idx == hdr_last) begin
          err_d[ERR_HDR]  = bad_hdr_q;
          err_d[ERR_CSUM] = !csum_ok;
          state_d         = (accept && (len_q != 16'd0)) ? ST_PAYLOAD : ST_DRAIN;
        end else if (idx == 16'd19) begin
          state_d = ST_OPT;
        end
      end
      ST_PAYLOAD: begin
        if (!rx_payload_ipv4) begin
          err_d[ERR_TRUNC] = 1'b1;
          state_d          = ST_DONE;
        end else begin
          fwd_d  = 1'b1;
          data_d = rx_payload;
          if (idx == tl_q - 16'd1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (!rx_payload_ipv4) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // vld_prev resets high so a frame already in progress when reset lifts is ignored.
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vld_prev_q <= 1'b1;
      cnt_q      <= 16'd0;
      ihl_q      <= 4'd0;
      tl_q       <= 16'd0;
      proto_q    <= 8'd0;
      src_q      <= 32'd0;
      dst_q      <= 32'd0;
      len_q      <= 16'd0;
      bad_hdr_q  <= 1'b0;
      err_q      <= 3'b000;
      fwd_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      vld_prev_q <= rx_payload_ipv4;
      cnt_q      <= cnt_d;
      ihl_q      <= ihl_d;
      tl_q       <= tl_d;
      proto_q    <= proto_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      bad_hdr_q  <= bad_hdr_d;
      err_q      <= err_d;
      fwd_q      <= fwd_d;
      data_q     <= data_d;
    end
  end

  assign rx_payload_udp = fwd_q;
  assign rx_udp_data    = data_q;
  assign rx_ip_src      = src_q;
  assign rx_ip_len      = len_q;
  assign rx_ip_err      = err_q;
  assign rv_irq_ipv4    = (state_q == ST_DONE);
  assign dbg_state_o    = state_q;

endmodule
